// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: counts cycles, data stalls, flushes and
// retirements from the CPU status signals. Collection stops after a
// programmable number of counted cycles.
//
// state | meaning
// IDLE  | not collecting; waiting for start_i
// RUN   | collecting; a cycle with start_i=1 is counted
// DONE  | cycle limit reached; counters frozen until clear/reset
module pipe_perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 30
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic [31:0]      pc_i,
  output logic [CNT_W-1:0] cycle_o,
  output logic [CNT_W-1:0] stall_o,
  output logic [CNT_W-1:0] flush_o,
  output logic [CNT_W-1:0] retire_o,
  output logic [CNT_W-1:0] stall_run_max_o,
  output logic [31:0]      last_pc_o,
  output logic             running_o,
  output logic             done_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] MAX_C = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cycle, r_stall, r_flush, r_retire, r_run, r_run_max;
  logic [31:0]      r_last_pc;
  logic             w_count;
  logic             w_dstall;
  logic [CNT_W-1:0] w_cycle_inc;
  logic [CNT_W-1:0] w_run_inc;
  logic             w_limit_hit;
  logic             w_running;
  logic             w_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != MAX_C)) return v + 1'b1;
    return v;
  endfunction

  // A branch in ID owns the stall, so it is not a data hazard.
  assign w_dstall    = stall_i & ~branch_i;
  assign w_count     = (r_state == S_RUN) & start_i & ~clear_i;
  assign w_cycle_inc = sat_inc(r_cycle, 1'b1);
  assign w_run_inc   = sat_inc(r_run, 1'b1);
  // Compare at 64 bits so a narrow CNT_W never aliases onto the limit.
  assign w_limit_hit = (CYCLE_LIMIT != 0) && (64'(w_cycle_inc) == 64'(CYCLE_LIMIT));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; clear_i forces IDLE from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start_i) w_state_nxt = S_RUN;
        S_RUN: begin
          if (!start_i)         w_state_nxt = S_IDLE;
          else if (w_limit_hit) w_state_nxt = S_DONE;
        end
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from the registered state.
  always_comb begin
    w_running = (r_state == S_RUN);
    w_done    = (r_state == S_DONE);
  end

  // Event counters and stall-run tracking; update only on counted cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_cycle   <= '0;
      r_stall   <= '0;
      r_flush   <= '0;
      r_retire  <= '0;
      r_run     <= '0;
      r_run_max <= '0;
      r_last_pc <= '0;
    end else if (w_count) begin
      r_cycle   <= w_cycle_inc;
      r_stall   <= sat_inc(r_stall, w_dstall);
      r_flush   <= sat_inc(r_flush, flush_i);
      r_retire  <= sat_inc(r_retire, retire_i);
      r_last_pc <= pc_i;
      if (w_dstall) begin
        r_run <= w_run_inc;
        if (w_run_inc > r_run_max) r_run_max <= w_run_inc;
      end else begin
        r_run <= '0;
      end
    end
  end

  assign cycle_o         = r_cycle;
  assign stall_o         = r_stall;
  assign flush_o         = r_flush;
  assign retire_o        = r_retire;
  assign stall_run_max_o = r_run_max;
  assign last_pc_o       = r_last_pc;
  assign running_o       = w_running;
  assign done_o          = w_done;

endmodule
